// File: rtl/psat_accum.sv
// Lane-wise saturating accumulator over BEATS packed 4x4-bit vectors; result registered, out_valid the cycle after the last beat.
// Input stalls (in_ready=0) while a result waits in HOLD; one idle cycle per completed result.
module psat_accum #(
  parameter int BEATS = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [3:0]       out_sat,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t           state, state_nxt;
  logic [15:0]      acc, acc_nxt;
  logic [3:0]       sat, sat_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [15:0]      sum_dat;
  logic [3:0]       sum_ovf;

  // Returns {overflow, clamped sum} for one signed 4-bit lane.
  function automatic logic [4:0] lane_add(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    logic       o;
    s = a + b;
    o = (a[3] == b[3]) && (s[3] != a[3]);
    if (o) s = a[3] ? 4'b1000 : 4'b0111;
    return {o, s};
  endfunction

  always_comb begin
    sum_dat = '0;
    sum_ovf = '0;
    for (int i = 0; i < 4; i++) begin
      {sum_ovf[i], sum_dat[4*i +: 4]} = lane_add(acc[4*i +: 4], in_data[4*i +: 4]);
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    sat_nxt   = sat;
    cnt_nxt   = beat_cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt = sum_dat;
          sat_nxt = sat | sum_ovf;
          if (beat_cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_nxt   = '0;
          sat_nxt   = '0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
    // Soft clear wins over both handshakes; a beat offered this cycle is lost.
    if (clear) begin
      acc_nxt   = '0;
      sat_nxt   = '0;
      cnt_nxt   = '0;
      state_nxt = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      sat      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      sat      <= sat_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  assign out_data = acc;
  assign out_sat  = sat;

endmodule

// File: tb/tb_psat_accum.sv
// Bench for psat_accum: integer lane model checked every cycle plus directed literal expectations.
module tb_psat_accum;

  localparam int BEATS = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, out_ready;
  logic [15:0]      in_data;
  logic             in_ready, out_valid;
  logic [15:0]      out_data;
  logic [3:0]       out_sat;
  logic [CNT_W-1:0] beat_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  psat_accum #(.BEATS(BEATS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: signed integer lane totals clamped to [-8,7], sticky flags, beat count, result-pending bit.
  int m_acc[4];
  bit m_sat[4];
  int m_cnt;
  bit m_hold;

  task automatic m_zero();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0;
      m_sat[i] = 1'b0;
    end
  endtask

  function automatic logic [15:0] m_data();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'(m_acc[i]);
    return d;
  endfunction

  function automatic logic [3:0] m_flags();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = m_sat[i];
    return f;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_zero(); m_cnt = 0; m_hold = 1'b0;
    end else if (clear) begin
      m_zero(); m_cnt = 0; m_hold = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_zero(); m_hold = 1'b0;
      end
    end else if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        logic signed [3:0] nib;
        int s;
        nib = in_data[4*i +: 4];
        s = m_acc[i] + int'(nib);
        if (s > 7) begin s = 7; m_sat[i] = 1'b1; end
        else if (s < -8) begin s = -8; m_sat[i] = 1'b1; end
        m_acc[i] = s;
      end
      m_cnt++;
      if (m_cnt == BEATS) begin
        m_cnt = 0;
        m_hold = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", 32'(in_ready), 32'(!m_hold));
      chk("m_out_valid", 32'(out_valid), 32'(m_hold));
      chk("m_beat_cnt", 32'(beat_cnt), 32'(m_cnt));
      if (m_hold) begin
        chk("m_out_data", 32'(out_data), 32'(m_data()));
        chk("m_out_sat", 32'(out_sat), 32'(m_flags()));
      end
    end
  end

  // Offers one beat and returns #1 after the edge that accepted it.
  task automatic beat(input logic [15:0] d);
    bit took;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      took = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 20);
    if (!took) begin
      tests++; fails++;
      $display("FAIL beat_accept: got no accept, expected accept within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run4(input logic [15:0] a, b, c, d, input logic [15:0] exp_d, input logic [3:0] exp_s, input string name);
    beat(a); beat(b); beat(c); beat(d);
    chk({name, "_vld"}, 32'(out_valid), 32'd1);
    chk({name, "_dat"}, 32'(out_data), 32'(exp_d));
    chk({name, "_sat"}, 32'(out_sat), 32'(exp_s));
  endtask

  initial begin
    logic [15:0] held;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_sat", 32'(out_sat), 32'h0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'h0);

    run4(16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h4444, 4'b0000, "plain");
    pop();
    // 7+1 clamps to 7 in every lane, then -2 per lane leaves 5.
    run4(16'h7777, 16'h1111, 16'hEEEE, 16'h0000, 16'h5555, 4'b1111, "pos_clamp");
    pop();
    // Lanes alternate -1/-2 after the clamp: 7-1=6, 7-2=5.
    run4(16'h7777, 16'h1111, 16'hFEFE, 16'h0000, 16'h6565, 4'b1111, "pos_mixed");
    pop();
    run4(16'h8888, 16'hFFFF, 16'h0000, 16'h0000, 16'h8888, 4'b1111, "neg_clamp");
    pop();
    run4(16'h7801, 16'h7801, 16'h7801, 16'h7801, 16'h7804, 4'b1100, "mixed");

    // Backpressure: result held and inputs stalled for 3 cycles.
    held = out_data;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stable", 32'(out_data), 32'(held));
    end
    in_valid = 1'b1; in_data = 16'h1111; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_cnt", 32'(beat_cnt), 32'd0);
    chk("bp_idle_vld", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_cnt", 32'(beat_cnt), 32'd1);
    chk("bp_next_dat", 32'(out_data), 32'h1111);

    // Synchronous reset mid-accumulation.
    beat(16'h3333);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_cnt", 32'(beat_cnt), 32'd0);
    chk("mrst_acc", 32'(out_data), 32'h0);
    run4(16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h4444, 4'b0000, "after_rst");
    pop();

    // Clear mid-accumulation, with a beat offered in the same cycle that must be dropped.
    beat(16'h3333); beat(16'h3333);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_cnt", 32'(beat_cnt), 32'd0);
    chk("clr_acc", 32'(out_data), 32'h0);
    run4(16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h4444, 4'b0000, "after_clr");

    // Clear while holding discards the result.
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_hold_vld", 32'(out_valid), 32'd0);
    chk("clr_hold_rdy", 32'(in_ready), 32'd1);
    chk("clr_hold_dat", 32'(out_data), 32'h0);

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
